seq_restoring_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider, the inverse datapath of the ripple

---
 rtl/seq_restoring_divider_if.sv | 24 ++
 rtl/seq_restoring_divider.sv | 123 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master launches operations; the divider (slave) returns registered results.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a
// WIDTH+1 bit trial subtract, with a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  // ~D is extended with a 1 so bit WIDTH of the sum is the borrow of R - D.
  always_comb begin
    shifted = {r_reg, q_reg[WIDTH-1]};
    trial   = shifted + {1'b1, ~d_reg} + (WIDTH + 1)'(1);
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = shifted[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Visible results load only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt           <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_reg <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (bus.divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= bus.dividend;
              dbz_reg       <= 1'b1;
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            dbz_reg       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vectors, an
// arithmetic reference model checked every cycle, and a full 4-bit sweep.
module tb_seq_restoring_divider;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   prev_start_cyc = 0;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int model_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference: an accepted op finishes WIDTH edges later (0 for /0), shows done
  // for one cycle, and the unit is free again one edge after that.
  bit m_inflight = 1'b0;
  int m_edge = 0;
  int m_fin  = 0;
  int m_q = 0, m_r = 0, m_dbz = 0;
  int p_q = 0, p_r = 0, p_dbz = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_inflight = 1'b0;
      m_q = 0;
      m_r = 0;
      m_dbz = 0;
    end else begin
      m_edge++;
      if (!m_inflight && bus.start) begin
        m_inflight = 1'b1;
        p_q   = model_q(int'(bus.dividend), int'(bus.divisor));
        p_r   = model_r(int'(bus.dividend), int'(bus.divisor));
        p_dbz = (bus.divisor == 0) ? 1 : 0;
        m_fin = m_edge + ((bus.divisor == 0) ? 0 : WIDTH);
      end else if (m_inflight && m_edge == m_fin + 1) begin
        m_inflight = 1'b0;
      end
      if (m_inflight && m_edge == m_fin) begin
        m_q   = p_q;
        m_r   = p_r;
        m_dbz = p_dbz;
      end
    end
    checkOutput("cyc_busy", int'(bus.busy), int'(m_inflight));
    checkOutput("cyc_done", int'(bus.done), (m_inflight && m_edge == m_fin) ? 1 : 0);
    checkOutput("cyc_quotient", int'(bus.quotient), m_q);
    checkOutput("cyc_remainder", int'(bus.remainder), m_r);
    checkOutput("cyc_div_by_zero", int'(bus.div_by_zero), m_dbz);
  end

  // Launch one op as soon as the unit is idle; lat is the number of clock
  // edges after the accepting edge at which done was raised.
  task automatic applyStimulus(input int a, input int b, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", int'(bus.busy), 0);
    prev_start_cyc = start_cyc;
    start_cyc      = cyc;
    bus.dividend = WIDTH'(a);
    bus.divisor  = WIDTH'(b);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom_range(MAXV));
    bus.divisor  = WIDTH'($urandom_range(MAXV));
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", int'(bus.done), 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int pulses;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    checkOutput("model_13_3_q", model_q(13, 3), 4);
    checkOutput("model_13_3_r", model_r(13, 3), 1);
    checkOutput("model_9_0_q", model_q(9, 0), 15);
    checkOutput("model_9_0_r", model_r(9, 0), 9);

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_quotient", int'(bus.quotient), 0);
    checkOutput("reset_remainder", int'(bus.remainder), 0);
    checkOutput("reset_div_by_zero", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    $display("[TB] test 1: 13/3");
    applyStimulus(13, 3, lat);
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_quotient", int'(bus.quotient), 4);
    checkOutput("t1_remainder", int'(bus.remainder), 1);
    checkOutput("t1_div_by_zero", int'(bus.div_by_zero), 0);

    $display("[TB] test 2: 15/1 then 7/9 back-to-back");
    applyStimulus(15, 1, lat);
    checkOutput("t2a_quotient", int'(bus.quotient), 15);
    checkOutput("t2a_remainder", int'(bus.remainder), 0);
    applyStimulus(7, 9, lat);
    checkOutput("t2_issue_interval", start_cyc - prev_start_cyc, 6);
    checkOutput("t2b_quotient", int'(bus.quotient), 0);
    checkOutput("t2b_remainder", int'(bus.remainder), 7);

    $display("[TB] test 3: divide by zero");
    applyStimulus(9, 0, lat);
    checkOutput("t3_latency", lat, 0);
    checkOutput("t3_quotient", int'(bus.quotient), 15);
    checkOutput("t3_remainder", int'(bus.remainder), 9);
    checkOutput("t3_div_by_zero", int'(bus.div_by_zero), 1);
    applyStimulus(8, 2, lat);
    checkOutput("t3b_quotient", int'(bus.quotient), 4);
    checkOutput("t3b_remainder", int'(bus.remainder), 0);
    checkOutput("t3b_div_by_zero", int'(bus.div_by_zero), 0);

    $display("[TB] test 4: start ignored while busy");
    @(negedge clk);
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
      bus.start = 1'b0;
      if (k == 2 || bus.done) begin
        bus.dividend = 4'd6;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
      end
    end
    bus.start = 1'b0;
    checkOutput("t4_done_pulses", pulses, 1);
    checkOutput("t4_quotient", int'(bus.quotient), 4);
    checkOutput("t4_remainder", int'(bus.remainder), 1);

    $display("[TB] test 5: asynchronous reset mid-operation");
    @(negedge clk);
    bus.dividend = 4'd14;
    bus.divisor  = 4'd5;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy_before", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", int'(bus.busy), 0);
    checkOutput("t5_done", int'(bus.done), 0);
    checkOutput("t5_quotient", int'(bus.quotient), 0);
    checkOutput("t5_remainder", int'(bus.remainder), 0);
    checkOutput("t5_div_by_zero", int'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(14, 5, lat);
    checkOutput("t5b_latency", lat, 4);
    checkOutput("t5b_quotient", int'(bus.quotient), 2);
    checkOutput("t5b_remainder", int'(bus.remainder), 4);

    $display("[TB] test 6: exhaustive sweep");
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        applyStimulus(a, b, lat);
        checkOutput("sweep_latency", lat, (b == 0) ? 0 : WIDTH);
        checkOutput("sweep_quotient", int'(bus.quotient), model_q(a, b));
        checkOutput("sweep_remainder", int'(bus.remainder), model_r(a, b));
        checkOutput("sweep_div_by_zero", int'(bus.div_by_zero), (b == 0) ? 1 : 0);
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
